// File: rtl/spi_mem_slave.sv
// SPI slave fronting a single-port RAM, with burst writes/reads through persistent wr/rd pointers.
// Define SPI_MEM_PARITY_EN to add an even-parity bit after every data word in both directions.
//
// state  | meaning
// IDLE   | no frame; the first SS_n-low edge samples cmd[1]
// CMD    | sampling cmd[0]
// ADDR   | shifting a pointer value, MSB first
// WDATA  | shifting write words, one RAM write per complete word
// RDUMMY | turnaround edge; first read word fetched and its MSB driven
// RDATA  | streaming read words on MISO, back-to-back
// HOLD   | pointer loaded, MOSI ignored until SS_n rises
module spi_mem_slave #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic SS_n,
    input  logic MOSI,
    output logic MISO,
    output logic frame_err
);
`ifdef SPI_MEM_PARITY_EN
    localparam int WLEN = DATA_WIDTH + 1;
`else
    localparam int WLEN = DATA_WIDTH;
`endif
    localparam int RX_W  = (ADDR_WIDTH > WLEN) ? ADDR_WIDTH - 1 : WLEN - 1;
    localparam int CNT_W = $clog2(((ADDR_WIDTH > WLEN) ? ADDR_WIDTH : WLEN) + 1);
    localparam logic [CNT_W-1:0] A_LAST = CNT_W'(ADDR_WIDTH - 1);
    localparam logic [CNT_W-1:0] W_LAST = CNT_W'(WLEN - 1);
    localparam logic [CNT_W-1:0] W_LEN  = CNT_W'(WLEN);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, RDUMMY, RDATA, HOLD} state_t;

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic [RX_W-1:0]       rx_sr, rx_nxt;
    logic [DATA_WIDTH-2:0] tx_sr, tx_nxt;
    logic                  cmd_hi, cmd_hi_nxt;
    logic [ADDR_WIDTH-1:0] wr_ptr, wr_ptr_nxt, rd_ptr, rd_ptr_nxt;
    logic [ADDR_WIDTH-1:0] addr_word;
    logic                  miso_nxt, err_nxt, mem_we;
    logic [DATA_WIDTH-1:0] mem_wdata, rd_word;
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
`ifdef SPI_MEM_PARITY_EN
    logic                  tx_par, tx_par_nxt;
`endif

    assign rd_word   = mem[rd_ptr];
    assign addr_word = {rx_sr[ADDR_WIDTH-2:0], MOSI};
`ifdef SPI_MEM_PARITY_EN
    assign mem_wdata = rx_sr[DATA_WIDTH-1:0];
`else
    assign mem_wdata = {rx_sr[DATA_WIDTH-2:0], MOSI};
`endif

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        rx_nxt     = rx_sr;
        tx_nxt     = tx_sr;
        cmd_hi_nxt = cmd_hi;
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        miso_nxt   = 1'b0;
        err_nxt    = 1'b0;
        mem_we     = 1'b0;
`ifdef SPI_MEM_PARITY_EN
        tx_par_nxt = tx_par;
`endif
        if (SS_n) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            err_nxt   = (state == CMD) || (((state == ADDR) || (state == WDATA)) && (cnt != '0));
        end else begin
            case (state)
                IDLE: begin
                    cmd_hi_nxt = MOSI;
                    state_nxt  = CMD;
                end
                CMD: begin
                    cnt_nxt = '0;
                    case ({cmd_hi, MOSI})
                        2'b01:   state_nxt = WDATA;
                        2'b11:   state_nxt = RDUMMY;
                        default: state_nxt = ADDR;
                    endcase
                end
                ADDR: begin
                    rx_nxt  = {rx_sr[RX_W-2:0], MOSI};
                    cnt_nxt = cnt + 1'b1;
                    if (cnt == A_LAST) begin
                        if (cmd_hi) rd_ptr_nxt = addr_word;
                        else        wr_ptr_nxt = addr_word;
                        cnt_nxt   = '0;
                        state_nxt = HOLD;
                    end
                end
                WDATA: begin
                    rx_nxt  = {rx_sr[RX_W-2:0], MOSI};
                    cnt_nxt = cnt + 1'b1;
                    if (cnt == W_LAST) begin
                        cnt_nxt = '0;
`ifdef SPI_MEM_PARITY_EN
                        // here MOSI is the parity bit; a bad word is dropped but the burst goes on
                        if ((^rx_sr[DATA_WIDTH-1:0]) == MOSI) begin
                            mem_we     = 1'b1;
                            wr_ptr_nxt = wr_ptr + 1'b1;
                        end else begin
                            err_nxt = 1'b1;
                        end
`else
                        mem_we     = 1'b1;
                        wr_ptr_nxt = wr_ptr + 1'b1;
`endif
                    end
                end
                RDUMMY, RDATA: begin
                    if ((state == RDUMMY) || (cnt == W_LEN)) begin
                        miso_nxt   = rd_word[DATA_WIDTH-1];
                        tx_nxt     = rd_word[DATA_WIDTH-2:0];
                        rd_ptr_nxt = rd_ptr + 1'b1;
                        cnt_nxt    = CNT_W'(1);
                        state_nxt  = RDATA;
`ifdef SPI_MEM_PARITY_EN
                        tx_par_nxt = ^rd_word;
`endif
                    end else begin
                        miso_nxt = tx_sr[DATA_WIDTH-2];
                        tx_nxt   = {tx_sr[DATA_WIDTH-3:0], 1'b0};
                        cnt_nxt  = cnt + 1'b1;
`ifdef SPI_MEM_PARITY_EN
                        if (cnt == W_LAST) miso_nxt = tx_par;
`endif
                    end
                end
                HOLD: state_nxt = HOLD;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            MISO      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            wr_ptr    <= wr_ptr_nxt;
            rd_ptr    <= rd_ptr_nxt;
            MISO      <= miso_nxt;
            frame_err <= err_nxt;
        end
    end

    // datapath registers and RAM carry no reset; RAM contents survive rst
    always_ff @(posedge clk) begin
        rx_sr  <= rx_nxt;
        tx_sr  <= tx_nxt;
        cmd_hi <= cmd_hi_nxt;
`ifdef SPI_MEM_PARITY_EN
        tx_par <= tx_par_nxt;
`endif
        if (mem_we && !rst) mem[wr_ptr] <= mem_wdata;
    end

endmodule

// File: doc/spi_mem_slave.md
Name: spi_mem_slave

Overview:
- Second-generation SPI slave with integrated single-port RAM, in one clock domain. Replaces the fixed 10-bit, single-word command/RAM pair.
- Generalises address and data widths, and adds auto-incrementing burst writes and burst reads within one SS_n-low frame.
- Adds independent write and read pointers and a frame-error pulse.
- Sits behind the chip-level SPI pins; MOSI is sampled on clk while SS_n is low.

Parameters:
- ADDR_WIDTH, 8: address bits. RAM depth is 2^ADDR_WIDTH words.
- DATA_WIDTH, 8: RAM word width and serial data word length.

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous reset, active-high
- SS_n  input  1  slave select, active-low; frame boundary
- MOSI  input  1  serial data in, MSB first, sampled when SS_n=0
- MISO  output  1  serial data out, MSB first, registered
- frame_err  output  1  one-cycle pulse on malformed frame end

Behaviour:
- Reset (rst=1 at an edge):
  - MISO=0, frame_err=0, state=IDLE, wr_ptr=0, rd_ptr=0, bit counter=0.
  - RAM contents not reset.
  - rst overrides any frame in progress.
- Edge numbering: edge 1 is the first rising edge with SS_n=0 after IDLE.
  - Edge 1 samples cmd[1]; edge 2 samples cmd[0].
- Commands (cmd[1:0]):
  - 00: load wr_ptr.
  - 01: write burst.
  - 10: load rd_ptr.
  - 11: read burst.
- States: IDLE, CMD, ADDR, WDATA, RDUMMY, RDATA, HOLD.
  - IDLE -> CMD: SS_n=0 (that edge samples cmd[1]).
  - CMD -> ADDR (00/10), WDATA (01), RDUMMY (11): after cmd[0].
  - ADDR: shift ADDR_WIDTH bits. On the last bit, load the selected pointer on that edge, then go to HOLD.
  - HOLD: ignore MOSI until SS_n=1.
  - WDATA: shift DATA_WIDTH bits. On the last bit, write mem[wr_ptr] on that edge and set wr_ptr=wr_ptr+1 mod 2^ADDR_WIDTH. Stay in WDATA for the next word.
  - RDUMMY: one cycle (edge 3). Loads the TX shift register with mem[rd_ptr]; rd_ptr+1.
  - RDATA: MISO presents word bit DATA_WIDTH-1 after edge 3, then one bit per edge, MSB first.
    - When the last bit is presented, the next edge reloads from mem[rd_ptr] and rd_ptr+1. Words stream back-to-back with no gap.
    - MOSI is ignored in RDATA.
- Any state with SS_n=1 at an edge -> IDLE; the bit counter clears.
  - A partial WDATA word is discarded (no RAM write, wr_ptr unchanged).
  - A partial ADDR word leaves the pointer unchanged.
- frame_err pulses for exactly the one edge following SS_n rise if the frame ended in:
  - CMD (fewer than 2 bits),
  - ADDR with 1..ADDR_WIDTH-1 bits, or
  - WDATA with 1..DATA_WIDTH-1 bits of a word.
  - No error for an RDATA/RDUMMY abort, or for SS_n rising on a word boundary.
- MISO=0 in every state except RDATA. MISO returns to 0 on the edge after SS_n rises.
- Pointers wrap: 2^ADDR_WIDTH-1 + 1 -> 0, in both burst directions.
- Read-only frames cannot alter RAM.
- wr_ptr and rd_ptr persist across frames; only rst or an explicit load changes them, apart from burst increments.
- SS_n low for exactly one edge: that edge samples cmd[1]; frame_err pulses after the rise.

Optional Feature:
- SPI_MEM_PARITY_EN defined:
  - Each WDATA word is followed by one even-parity bit (word length DATA_WIDTH+1).
  - On parity mismatch: no RAM write, wr_ptr unchanged, frame_err pulses on the edge after the parity bit.
  - The burst continues with the next word.
  - In RDATA, an even-parity bit is appended after each word's LSB (words are DATA_WIDTH+1 bits apart).
- SPI_MEM_PARITY_EN undefined: no parity bits anywhere; words are DATA_WIDTH bits.

Test Plan:
- rst=1 for 2 edges mid-WDATA -> MISO=0, frame_err=0, wr_ptr=rd_ptr=0; a subsequent read of addr 0 returns prior RAM value (RAM not cleared).
- Frame 00+0x10, then frame 01 + 0xA5,0x3C,0xFF; frame 10+0x10, then frame 11 for 3 words -> MISO streams 0xA5,0x3C,0xFF contiguous, MSB first, first bit after edge 3.
- Wrap: load wr_ptr=0xFF, write 0x11,0x22; read from 0xFF for 2 words -> 0x11 then 0x22 (addr 0x00).
- Write frame 01 with 0x77 then 5 bits of a second word, SS_n rises -> frame_err one-cycle pulse; mem[ptr+1] unchanged; wr_ptr advanced by exactly 1.
- Frame 00 with only 4 address bits -> frame_err pulse, wr_ptr unchanged; frame 11 aborted after 3 bits -> no frame_err, MISO=0 next edge.
- With SPI_MEM_PARITY_EN: write 0x03 with parity 1 -> not written, frame_err pulses; write 0x03 with parity 0 -> written; readback gives 0x03 then parity 0.
